fib_stream_checker: RTL

- Downstream consumer of the Fibonacci generator's `out` stream; checks every valid sample against the expected sequence 1, 1, 2, 3, 5, …
- Reports lock, first-mismatch index, term count and arithmetic wrap.
- Sits in the verification/monitor path beside the generator; registered outputs, no backpressure.

---
 rtl/fib_stream_checker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fib_stream_checker.sv
// Monitors a Fibonacci term stream (1,1,2,3,5,...) and reports lock, first mismatch, term count and wrap.
// Optional generator-restart resync in ERROR is enabled by defining FIB_CHECK_RESYNC_EN.
module fib_stream_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  locked,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  err_index,
  output logic [CNT_WIDTH-1:0]  term_count,
  output logic                  wrapped,
  output logic [DATA_WIDTH-1:0] expected
);

  typedef enum logic [1:0] {IDLE, GOT1, RUN, ERROR} state_t;

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] TWO = DATA_WIDTH'(2);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] prev, prev_nxt, expected_nxt;
  logic                  locked_nxt, error_nxt, wrapped_nxt;
  logic [CNT_WIDTH-1:0]  err_index_nxt, term_count_nxt;
  logic                  match;
  logic [DATA_WIDTH:0]   sum;
  logic [CNT_WIDTH-1:0]  count_inc;
`ifdef FIB_CHECK_RESYNC_EN
  logic                  is_one;
  assign is_one = (in_data == ONE);
`endif

  assign match     = in_valid && (in_data == expected);
  // The carry bit of the full-width sum is what flags arithmetic wrap.
  assign sum       = {1'b0, prev} + {1'b0, in_data};
  assign count_inc = (term_count == '1) ? term_count : term_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked     <= 1'b0;
      error      <= 1'b0;
      err_index  <= '0;
      term_count <= '0;
      wrapped    <= 1'b0;
      expected   <= ONE;
      prev       <= '0;
    end else begin
      locked     <= locked_nxt;
      error      <= error_nxt;
      err_index  <= err_index_nxt;
      term_count <= term_count_nxt;
      wrapped    <= wrapped_nxt;
      expected   <= expected_nxt;
      prev       <= prev_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      case (state)
        IDLE:    state_nxt = match ? GOT1 : ERROR;
        GOT1:    state_nxt = match ? RUN : ERROR;
        RUN:     state_nxt = match ? RUN : ERROR;
        ERROR: begin
`ifdef FIB_CHECK_RESYNC_EN
          if (is_one) state_nxt = GOT1;
`else
          state_nxt = ERROR;
`endif
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    locked_nxt     = locked;
    error_nxt      = error;
    err_index_nxt  = err_index;
    term_count_nxt = term_count;
    wrapped_nxt    = wrapped;
    expected_nxt   = expected;
    prev_nxt       = prev;
    if (in_valid) begin
      case (state)
        IDLE, GOT1, RUN: begin
          if (match) begin
            term_count_nxt = count_inc;
            if (state == IDLE) begin
              prev_nxt     = ONE;
              expected_nxt = ONE;
            end else if (state == GOT1) begin
              locked_nxt   = 1'b1;
              prev_nxt     = ONE;
              expected_nxt = TWO;
            end else begin
              prev_nxt     = in_data;
              expected_nxt = sum[DATA_WIDTH-1:0];
              if (sum[DATA_WIDTH]) wrapped_nxt = 1'b1;
            end
          end else begin
            // Only the first mismatch ever records an index; a resynced stream keeps it.
            locked_nxt = 1'b0;
            error_nxt  = 1'b1;
            if (!error) err_index_nxt = term_count;
          end
        end
        ERROR: begin
`ifdef FIB_CHECK_RESYNC_EN
          if (is_one) begin
            prev_nxt       = ONE;
            expected_nxt   = ONE;
            term_count_nxt = CNT_WIDTH'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
